// File: rtl/ex_mem_req.sv
// EX-stage memory-request unit: holds one EX instruction, issues its load/store
// on a req/addr_ok/data_ok split-transaction bus, flags misaligned addresses
// (ALE) instead of issuing, and tracks outstanding requests so responses that
// belong to flushed instructions are swallowed instead of reaching MEM.
module ex_mem_req #(
  parameter int DATA_W          = 32,
  parameter int PAYLOAD_W       = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_allow,
  input  logic [PAYLOAD_W-1:0]                   in_payload,
  input  logic                                   in_load,
  input  logic                                   in_store,
  input  logic [1:0]                             in_size,
  input  logic [31:0]                            in_addr,
  input  logic [DATA_W-1:0]                      in_wdata,
  output logic                                   data_req,
  output logic                                   data_wr,
  output logic [1:0]                             data_size,
  output logic [31:0]                            data_addr,
  output logic [DATA_W/8-1:0]                    data_wstrb,
  output logic [DATA_W-1:0]                      data_wdata,
  input  logic                                   data_addr_ok,
  input  logic                                   data_data_ok,
  output logic                                   out_valid,
  input  logic                                   out_allow,
  output logic [PAYLOAD_W-1:0]                   out_payload,
  output logic                                   out_ale,
  output logic                                   out_wait_data,
  output logic                                   resp_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   inflight
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // Stage registers
  logic                 valid_reg;
  logic [PAYLOAD_W-1:0] payload_reg;
  logic                 load_reg;
  logic                 store_reg;
  logic [1:0]           size_reg;
  logic [31:0]          addr_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic                 issued_reg;

  // Bus bookkeeping: inflight counts every accepted-but-unanswered request,
  // including the ones already marked for cancellation.
  logic [CNT_W-1:0]     inflight_reg;
  logic [CNT_W-1:0]     inflight_next;
  logic [CNT_W-1:0]     cancel_reg;
  logic [CNT_W-1:0]     cancel_next;

  logic                 mem_op;
  logic [31:0]          size_mask;
  logic                 ale;
  logic                 slot_free;
  logic                 req;
  logic                 accept;
  logic                 ready_go;
  logic                 capture;
  logic                 dok;
  logic                 drop;
  logic [31:0]          lane_off;
  logic [31:0]          lane_cnt;

  assign mem_op    = load_reg | store_reg;
  assign size_mask = (32'd1 << size_reg) - 32'd1;
  assign ale       = valid_reg & mem_op & (|(addr_reg & size_mask));
  assign slot_free = inflight_reg < MAX_CNT;

  // No request in a flush cycle so a killed instruction never reaches the bus.
  assign req       = valid_reg & mem_op & ~ale & ~issued_reg & slot_free & ~flush;
  assign accept    = req & data_addr_ok;

  // A same-cycle accept lets the instruction move on without an extra cycle.
  assign ready_go  = ~mem_op | ale | issued_reg | accept;
  assign out_valid = valid_reg & ready_go;
  assign in_allow  = ~valid_reg | (ready_go & out_allow);
  assign capture   = in_valid & in_allow & ~flush;

  // A data_ok with nothing outstanding is a bus error and is ignored entirely.
  assign dok           = data_data_ok & (inflight_reg != '0);
  assign drop          = dok & (cancel_reg != '0);
  assign resp_valid    = dok & ~drop & ~flush;
  assign inflight_next = inflight_reg + CNT_W'(accept) - CNT_W'(dok);
  // On flush every request still outstanding after this cycle becomes stale.
  assign cancel_next   = flush ? inflight_next : (cancel_reg - CNT_W'(drop));

  assign data_req      = req;
  assign data_wr       = store_reg;
  assign data_size     = size_reg;
  assign data_addr     = addr_reg;
  assign out_payload   = payload_reg;
  assign out_ale       = ale;
  assign out_wait_data = valid_reg & mem_op & ~ale;
  assign inflight      = inflight_reg;

  // Byte lanes [off, off + 2**size) are enabled, matching a mask of
  // (2**size) ones shifted by the in-word offset and truncated to the bus.
  assign lane_off = 32'(addr_reg[OFF_W-1:0]);
  assign lane_cnt = 32'd1 << size_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
      logic [OFF_W-1:0] src;
      // Each lane takes the store byte at its position modulo the access size.
      assign src = LANE & size_mask[OFF_W-1:0];
      assign data_wdata[gi*8 +: 8] = wdata_reg[{src, 3'b000} +: 8];
      assign data_wstrb[gi] = store_reg & (32'(gi) >= lane_off) &
                              (32'(gi) < (lane_off + lane_cnt));
    end
  endgenerate

  // Stage register: capture a new instruction, hand off, or kill on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      payload_reg <= '0;
      load_reg    <= 1'b0;
      store_reg   <= 1'b0;
      size_reg    <= 2'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= '0;
      issued_reg  <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      valid_reg   <= 1'b1;
      payload_reg <= in_payload;
      load_reg    <= in_load;
      store_reg   <= in_store;
      size_reg    <= in_size;
      addr_reg    <= in_addr;
      wdata_reg   <= in_wdata;
      issued_reg  <= 1'b0;
    end else begin
      if (out_valid && out_allow) begin
        valid_reg <= 1'b0;
      end
      if (accept) begin
        issued_reg <= 1'b1;
      end
    end
  end

  // Outstanding-request and cancel counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
      cancel_reg   <= '0;
    end else begin
      inflight_reg <= inflight_next;
      cancel_reg   <= cancel_next;
    end
  end

endmodule

// File: tb/tb_ex_mem_req.sv
// Directed bench for ex_mem_req: a 32-bit instance carries the main sequence,
// a 64-bit instance covers wide-bus strobe and replication.
module tb_ex_mem_req;

  logic        clk;
  logic        reset;
  logic        flush;

  // 32-bit instance
  logic        in_valid, in_allow, in_load, in_store;
  logic [63:0] in_payload;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        out_valid, out_allow, out_ale, out_wait_data, resp_valid;
  logic [63:0] out_payload;
  logic [1:0]  inflight;

  // 64-bit instance
  logic        w_in_valid, w_in_allow, w_in_load, w_in_store;
  logic [63:0] w_in_payload;
  logic [1:0]  w_in_size;
  logic [31:0] w_in_addr;
  logic [63:0] w_in_wdata;
  logic        w_data_req, w_data_wr, w_data_addr_ok, w_data_data_ok;
  logic [1:0]  w_data_size;
  logic [31:0] w_data_addr;
  logic [63:0] w_data_wdata;
  logic [7:0]  w_data_wstrb;
  logic        w_out_valid, w_out_allow, w_out_ale, w_out_wait_data, w_resp_valid;
  logic [63:0] w_out_payload;
  logic [1:0]  w_inflight;

  int checks = 0;
  int errors = 0;

  ex_mem_req #(.DATA_W(32), .PAYLOAD_W(64), .MAX_OUTSTANDING(2)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_allow(in_allow), .in_payload(in_payload),
    .in_load(in_load), .in_store(in_store), .in_size(in_size),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .out_valid(out_valid), .out_allow(out_allow), .out_payload(out_payload),
    .out_ale(out_ale), .out_wait_data(out_wait_data),
    .resp_valid(resp_valid), .inflight(inflight)
  );

  ex_mem_req #(.DATA_W(64), .PAYLOAD_W(64), .MAX_OUTSTANDING(2)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(w_in_valid), .in_allow(w_in_allow), .in_payload(w_in_payload),
    .in_load(w_in_load), .in_store(w_in_store), .in_size(w_in_size),
    .in_addr(w_in_addr), .in_wdata(w_in_wdata),
    .data_req(w_data_req), .data_wr(w_data_wr), .data_size(w_data_size),
    .data_addr(w_data_addr), .data_wstrb(w_data_wstrb), .data_wdata(w_data_wdata),
    .data_addr_ok(w_data_addr_ok), .data_data_ok(w_data_data_ok),
    .out_valid(w_out_valid), .out_allow(w_out_allow), .out_payload(w_out_payload),
    .out_ale(w_out_ale), .out_wait_data(w_out_wait_data),
    .resp_valid(w_resp_valid), .inflight(w_inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [63:0] pl);
    in_valid   = v;
    in_load    = ld;
    in_store   = st;
    in_size    = sz;
    in_addr    = a;
    in_wdata   = wd;
    in_payload = pl;
    if (v) $display("txn32 load=%0b store=%0b size=%0d addr=%h wdata=%h", ld, st, sz, a, wd);
  endtask

  task automatic clr_in();
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    clr_in();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; out_allow = 1'b1;
    w_in_valid = 1'b0; w_in_load = 1'b0; w_in_store = 1'b0; w_in_size = 2'd0;
    w_in_addr = 32'd0; w_in_wdata = 64'd0; w_in_payload = 64'd0;
    w_data_addr_ok = 1'b1; w_data_data_ok = 1'b0; w_out_allow = 1'b1;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_data_req",   {63'd0, data_req},   64'd0);
    chk("rst_out_valid",  {63'd0, out_valid},  64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_out_ale",    {63'd0, out_ale},    64'd0);
    chk("rst_in_allow",   {63'd0, in_allow},   64'd1);
    chk("rst_inflight",   {62'd0, inflight},   64'd0);
    chk("rst_wstrb",      {60'd0, data_wstrb}, 64'd0);
    chk("rst_in_allow64", {63'd0, w_in_allow}, 64'd1);
    reset = 1'b0;
    data_addr_ok = 1'b1;
    tick();

    // Aligned word store, immediate addr_ok
    set_in(1'b1, 1'b0, 1'b1, 2'd2, 32'h1004, 32'hAABBCCDD, 64'h1111);
    tick(); clr_in(); #1;
    chk("sw_req",      {63'd0, data_req},      64'd1);
    chk("sw_wr",       {63'd0, data_wr},       64'd1);
    chk("sw_addr",     {32'd0, data_addr},     64'h1004);
    chk("sw_wstrb",    {60'd0, data_wstrb},    64'hF);
    chk("sw_wdata",    {32'd0, data_wdata},    64'hAABBCCDD);
    chk("sw_out_valid",{63'd0, out_valid},     64'd1);
    chk("sw_ale",      {63'd0, out_ale},       64'd0);
    chk("sw_payload",  out_payload,            64'h1111);
    chk("sw_wait",     {63'd0, out_wait_data}, 64'd1);
    tick();
    chk("sw_inflight1",{62'd0, inflight},      64'd1);
    chk("sw_req_low",  {63'd0, data_req},      64'd0);
    data_data_ok = 1'b1; #1;
    chk("sw_resp",     {63'd0, resp_valid},    64'd1);
    tick(); data_data_ok = 1'b0;
    chk("sw_inflight0",{62'd0, inflight},      64'd0);

    // Byte store at offset 3
    set_in(1'b1, 1'b0, 1'b1, 2'd0, 32'h1003, 32'h000000EE, 64'h2222);
    tick(); clr_in(); #1;
    chk("sb_wstrb", {60'd0, data_wstrb}, 64'h8);
    chk("sb_wdata", {32'd0, data_wdata}, 64'hEEEEEEEE);
    tick(); data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;

    // Half store at offset 2
    set_in(1'b1, 1'b0, 1'b1, 2'd1, 32'h1002, 32'h12345678, 64'h3333);
    tick(); clr_in(); #1;
    chk("sh_wstrb", {60'd0, data_wstrb}, 64'hC);
    chk("sh_wdata", {32'd0, data_wdata}, 64'h56785678);
    tick(); data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
    chk("sh_inflight0", {62'd0, inflight}, 64'd0);

    // Misaligned word load raises ALE, no request
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h1002, 32'd0, 64'h4444);
    tick(); clr_in(); #1;
    chk("ale_flag",  {63'd0, out_ale},       64'd1);
    chk("ale_req",   {63'd0, data_req},      64'd0);
    chk("ale_valid", {63'd0, out_valid},     64'd1);
    chk("ale_wait",  {63'd0, out_wait_data}, 64'd0);
    tick();
    chk("ale_inflight", {62'd0, inflight},   64'd0);
    chk("ale_cleared",  {63'd0, out_ale},    64'd0);

    // Back-to-back loads until the outstanding limit
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h100, 32'd0, 64'hA);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h104, 32'd0, 64'hB);
    #1;
    chk("ldA_req",   {63'd0, data_req},  64'd1);
    chk("ldA_allow", {63'd0, in_allow},  64'd1);
    chk("ldA_addr",  {32'd0, data_addr}, 64'h100);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h108, 32'd0, 64'hC);
    #1;
    chk("ldB_req",      {63'd0, data_req},  64'd1);
    chk("ldB_addr",     {32'd0, data_addr}, 64'h104);
    chk("ldB_inflight", {62'd0, inflight},  64'd1);
    tick(); clr_in(); #1;
    chk("ldC_inflight", {62'd0, inflight},  64'd2);
    chk("ldC_req_held", {63'd0, data_req},  64'd0);
    chk("ldC_valid",    {63'd0, out_valid}, 64'd0);
    chk("ldC_allow",    {63'd0, in_allow},  64'd0);
    tick();
    chk("ldC_req_held2",{63'd0, data_req},  64'd0);
    data_data_ok = 1'b1; #1;
    chk("ldC_resp1",    {63'd0, resp_valid},64'd1);
    chk("ldC_req_dok",  {63'd0, data_req},  64'd0);
    tick(); #1;
    chk("ldC_req_free", {63'd0, data_req},  64'd1);
    chk("ldC_go",       {63'd0, out_valid}, 64'd1);
    chk("ldC_addr",     {32'd0, data_addr}, 64'h108);
    tick(); #1;
    chk("acc_dok_inflight", {62'd0, inflight},   64'd1);
    chk("ldC_gone",         {63'd0, out_valid},  64'd0);
    tick(); data_data_ok = 1'b0; #1;
    chk("ld_drained",       {62'd0, inflight},   64'd0);

    // addr_ok stall keeps the request stable
    data_addr_ok = 1'b0;
    set_in(1'b1, 1'b0, 1'b1, 2'd2, 32'h200, 32'hCAFEF00D, 64'h5555);
    tick(); clr_in(); #1;
    chk("stall_req",   {63'd0, data_req},  64'd1);
    chk("stall_valid", {63'd0, out_valid}, 64'd0);
    tick(); tick(); #1;
    chk("stall_req2",  {63'd0, data_req},   64'd1);
    chk("stall_addr",  {32'd0, data_addr},  64'h200);
    chk("stall_wdata", {32'd0, data_wdata}, 64'hCAFEF00D);
    chk("stall_wstrb", {60'd0, data_wstrb}, 64'hF);
    data_addr_ok = 1'b1; #1;
    chk("stall_go",    {63'd0, out_valid},  64'd1);
    tick();
    chk("stall_inflight", {62'd0, inflight}, 64'd1);
    data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;

    // Two accepted loads, then flush cancels both responses
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h300, 32'd0, 64'h6);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h304, 32'd0, 64'h7);
    tick(); clr_in();
    tick(); #1;
    chk("fl_inflight2", {62'd0, inflight}, 64'd2);
    flush = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h308, 32'd0, 64'h8);
    #1;
    chk("fl_req_low", {63'd0, data_req}, 64'd0);
    tick(); flush = 1'b0; clr_in(); #1;
    chk("fl_not_captured", {63'd0, out_valid}, 64'd0);
    chk("fl_no_req",       {63'd0, data_req},  64'd0);
    data_data_ok = 1'b1; #1;
    chk("fl_cancel_resp1", {63'd0, resp_valid}, 64'd0);
    tick(); #1;
    chk("fl_cancel_resp2", {63'd0, resp_valid}, 64'd0);
    tick(); data_data_ok = 1'b0; #1;
    chk("fl_inflight0",    {62'd0, inflight},   64'd0);
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h30C, 32'd0, 64'h9);
    tick(); clr_in();
    tick();
    data_data_ok = 1'b1; #1;
    chk("fl_after_resp",   {63'd0, resp_valid}, 64'd1);
    tick(); data_data_ok = 1'b0;

    // Flush kills a stalled instruction
    data_addr_ok = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h400, 32'd0, 64'hF);
    tick(); clr_in(); #1;
    chk("fk_req", {63'd0, data_req}, 64'd1);
    flush = 1'b1; #1;
    chk("fk_req_suppressed", {63'd0, data_req}, 64'd0);
    tick(); flush = 1'b0; #1;
    chk("fk_valid", {63'd0, out_valid}, 64'd0);
    chk("fk_allow", {63'd0, in_allow},  64'd1);
    chk("fk_inflight", {62'd0, inflight}, 64'd0);
    data_addr_ok = 1'b1;

    // Reset mid-transaction clears the counter
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 32'h500, 32'd0, 64'h10);
    tick(); clr_in();
    tick();
    chk("mr_inflight1", {62'd0, inflight}, 64'd1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("mr_inflight0", {62'd0, inflight}, 64'd0);

    // 64-bit bus: doubleword and upper-word stores
    w_in_valid = 1'b1; w_in_store = 1'b1; w_in_size = 2'd3;
    w_in_addr = 32'h2000; w_in_wdata = 64'h1122334455667788;
    $display("txn64 store size=3 addr=%h wdata=%h", w_in_addr, w_in_wdata);
    tick(); w_in_valid = 1'b0; #1;
    chk("w64_d_wstrb", {56'd0, w_data_wstrb}, 64'hFF);
    chk("w64_d_wdata", w_data_wdata,          64'h1122334455667788);
    chk("w64_d_req",   {63'd0, w_data_req},   64'd1);
    tick();
    w_data_data_ok = 1'b1; tick(); w_data_data_ok = 1'b0;
    w_in_valid = 1'b1; w_in_store = 1'b1; w_in_size = 2'd2;
    w_in_addr = 32'h2004; w_in_wdata = 64'h00000000AABBCCDD;
    $display("txn64 store size=2 addr=%h wdata=%h", w_in_addr, w_in_wdata);
    tick(); w_in_valid = 1'b0; #1;
    chk("w64_w_wstrb", {56'd0, w_data_wstrb}, 64'hF0);
    chk("w64_w_wdata", w_data_wdata,          64'hAABBCCDDAABBCCDD);
    tick();
    w_data_data_ok = 1'b1; tick(); w_data_data_ok = 1'b0; #1;
    chk("w64_inflight0", {62'd0, w_inflight}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_req.md
# ex_mem_req

Parametrised EX-stage memory-request unit that replaces the single-cycle SRAM port with a req/addr_ok/data_ok split-transaction bus. It holds one EX instruction, issues its load/store request, and checks alignment (raising ALE instead of issuing on a misaligned address). It tracks up to MAX_OUTSTANDING accepted requests and discards data_ok responses belonging to flushed instructions. It sits between the ID→EX pipeline register and the MEM stage.

## Interface
Parameters:
- DATA_W, 32, bus data width; 32 or 64.
- PAYLOAD_W, 64, opaque per-instruction bits carried to MEM (pc, dest, gr_we, …).
- MAX_OUTSTANDING, 2, maximum requests accepted by addr_ok but not yet answered by data_ok; ≥1.

Ports (clock and reset first):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  exception/ertn flush; kills the stage and all in-flight responses.
- in_valid  in  1  ID→EX valid.
- in_allow  out  1  EX allow_in.
- in_payload  in  PAYLOAD_W  pass-through bits.
- in_load, in_store  in  1 each  memory op (mutually exclusive).
- in_size  in  2  log2 access bytes; values > log2(DATA_W/8) are illegal.
- in_addr  in  32  effective address (ALU result).
- in_wdata  in  DATA_W  store source (low bytes significant).
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  = latched size.
- data_addr  out  32  full byte address.
- data_wstrb  out  DATA_W/8  byte enables.
- data_wdata  out  DATA_W  lane-replicated store data.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  one response returned.
- out_valid  out  1  EX→MEM valid.
- out_allow  in  1  MEM allow_in.
- out_payload  out  PAYLOAD_W  latched payload.
- out_ale  out  1  misaligned address; no request issued.
- out_wait_data  out  1  MEM must wait for a data_ok.
- resp_valid  out  1  data_data_ok forwarded to MEM (not cancelled).
- inflight  out  clog2(MAX_OUTSTANDING+1)  outstanding count.

## Operation
- Stage registers: valid, payload, op, size, addr, wdata, issued. Loaded when in_valid & in_allow; issued cleared on load.
- ale = valid & (load|store) & (addr & ((1<<size)-1)) != 0.
- data_req = valid & (load|store) & ~ale & ~issued & (inflight < MAX_OUTSTANDING) & ~flush.
- accept = data_req & data_addr_ok → issued ← 1, inflight +1.
- data_wstrb: ((1<<(1<<size))-1) << addr[log2(DATA_W/8)-1:0]; zero when ~store.
- data_wdata: in_wdata low (1<<size) bytes replicated across DATA_W.
- ready_go = ~(load|store) | ale | issued | accept (same-cycle accept may advance).
- out_valid = valid & ready_go; in_allow = ~valid | (ready_go & out_allow).
- out_wait_data = (load|store) & ~ale.
- Response handling: if data_ok & cancel≠0 → cancel −1, resp_valid 0; else resp_valid = data_ok & ~flush.
- inflight_next = inflight + accept − data_ok (data_ok with inflight=0 is a bus error, ignored).
- flush: valid ← 0; cancel ← inflight_next (+ cancel_next if nonzero); req suppressed in the flush cycle.
- Requests are issued in order; data_ok is assumed in order.

## Timing
- Reset: valid, issued, inflight, cancel = 0; all outputs 0 (data_req, out_valid, resp_valid, out_ale = 0; in_allow = 1).
- Best case: req & addr_ok in the same cycle as EX occupancy → out_valid that cycle (zero added latency).
- addr_ok stall: data_req held stable (addr/size/wstrb/wdata unchanged) until accepted or flushed.
- inflight = MAX_OUTSTANDING: req held low; no request is issued and data_ok frees a slot next cycle.
- Simultaneous accept & data_ok: inflight unchanged.
- flush with in_valid: the new instruction is not captured.
- reset mid-transaction: counters cleared; the bench must also reset the bus model.

## Test plan
- Aligned word store, addr 0x1004, wdata 0xAABBCCDD, addr_ok immediate → data_req=1, wstrb 4'b1111, out_valid same cycle, out_ale=0.
- Byte store size 0, addr 0x1003, wdata 0x..EE → wstrb 4'b1000, wdata 0xEEEEEEEE; half store at 0x1002 → wstrb 4'b1100.
- Load word at 0x1002 → out_ale=1, data_req never asserted, inflight stays 0, out_valid=1.
- Two back-to-back loads with data_ok delayed 5 cycles, MAX_OUTSTANDING=2 → both issue, inflight=2, third load holds req low until first data_ok.
- Two loads accepted, then flush → next two data_ok give resp_valid=0, cancel 2→0; a following load's data_ok gives resp_valid=1.
- DATA_W=64: size 3 at 0x2000 → wstrb 8'hFF; size 2 at 0x2004 → wstrb 8'hF0.
